// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode types.
//  - OPC_* : major opcode values (instr[6:0])
//  - op_t  : decoded operation handed to execute
//  - imm_fmt_t / gen_imm : immediate format and its sign-extended value
//  - decoded_t : everything the decode stage needs from one instruction word
package riscv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // OP_NOP must stay at encoding 0: it is the reset value of ex_op.
  typedef enum logic [5:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ECALL, OP_EBREAK, OP_ILLEGAL
  } op_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        wr_rd;
    logic [31:0] imm;
    logic        illegal;
  } decoded_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_t fmt);
    case (fmt)
      IMM_I:   gen_imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   gen_imm = {i[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: gen_imm = 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// rv_decoder: purely combinational RV32I decoder.
//  instr in  32         instruction word
//  dec   out decoded_t  operation, register fields, usage flags, immediate
// Illegal words come out as OP_ILLEGAL with no register usage, so they can
// neither stall nor mark the scoreboard.
module rv_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_fmt_t   fmt;
  logic       bad;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    dec          = '0;
    dec.op       = OP_NOP;
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    fmt          = IMM_NONE;
    bad          = 1'b0;
    case (opcode)
      OPC_LUI:   begin dec.op = OP_LUI;   dec.wr_rd = 1'b1; fmt = IMM_U; end
      OPC_AUIPC: begin dec.op = OP_AUIPC; dec.wr_rd = 1'b1; fmt = IMM_U; end
      OPC_JAL:   begin dec.op = OP_JAL;   dec.wr_rd = 1'b1; fmt = IMM_J; end
      OPC_JALR: begin
        dec.op = OP_JALR; dec.uses_rs1 = 1'b1; dec.wr_rd = 1'b1; fmt = IMM_I;
        bad = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; fmt = IMM_B;
        case (f3)
          3'b000:  dec.op = OP_BEQ;
          3'b001:  dec.op = OP_BNE;
          3'b100:  dec.op = OP_BLT;
          3'b101:  dec.op = OP_BGE;
          3'b110:  dec.op = OP_BLTU;
          3'b111:  dec.op = OP_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.uses_rs1 = 1'b1; dec.wr_rd = 1'b1; fmt = IMM_I;
        case (f3)
          3'b000:  dec.op = OP_LB;
          3'b001:  dec.op = OP_LH;
          3'b010:  dec.op = OP_LW;
          3'b100:  dec.op = OP_LBU;
          3'b101:  dec.op = OP_LHU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; fmt = IMM_S;
        case (f3)
          3'b000:  dec.op = OP_SB;
          3'b001:  dec.op = OP_SH;
          3'b010:  dec.op = OP_SW;
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec.uses_rs1 = 1'b1; dec.wr_rd = 1'b1; fmt = IMM_I;
        case (f3)
          3'b000: dec.op = OP_ADDI;
          3'b010: dec.op = OP_SLTI;
          3'b011: dec.op = OP_SLTIU;
          3'b100: dec.op = OP_XORI;
          3'b110: dec.op = OP_ORI;
          3'b111: dec.op = OP_ANDI;
          3'b001: begin dec.op = OP_SLLI; bad = (f7 != 7'b0000000); end
          default: begin
            if (f7 == 7'b0000000)      dec.op = OP_SRLI;
            else if (f7 == 7'b0100000) dec.op = OP_SRAI;
            else                       bad = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.wr_rd = 1'b1;
        case ({f7, f3})
          10'b0000000_000: dec.op = OP_ADD;
          10'b0100000_000: dec.op = OP_SUB;
          10'b0000000_001: dec.op = OP_SLL;
          10'b0000000_010: dec.op = OP_SLT;
          10'b0000000_011: dec.op = OP_SLTU;
          10'b0000000_100: dec.op = OP_XOR;
          10'b0000000_101: dec.op = OP_SRL;
          10'b0100000_101: dec.op = OP_SRA;
          10'b0000000_110: dec.op = OP_OR;
          10'b0000000_111: dec.op = OP_AND;
          default:         bad = 1'b1;
        endcase
      end
      // FENCE has no effect on a single in-order pipe; it travels as a NOP.
      OPC_MISC_MEM: bad = (f3 != 3'b000);
      OPC_SYSTEM: begin
        if (instr == 32'h0000_0073)      dec.op = OP_ECALL;
        else if (instr == 32'h0010_0073) dec.op = OP_EBREAK;
        else                             bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
    if (bad) begin
      dec.op       = OP_ILLEGAL;
      dec.uses_rs1 = 1'b0;
      dec.uses_rs2 = 1'b0;
      dec.wr_rd    = 1'b0;
      fmt          = IMM_NONE;
    end
    dec.imm     = gen_imm(instr, fmt);
    dec.illegal = bad;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode between fetch and execute.
//  clk, rst (async, active-high), flush (sync kill of the ID/EX entry)
//  if_valid/if_ready/if_instr/if_pc    : fetch side
//  rf_en/rf_reg_a/rf_reg_b/rf_data_a/b : register-file read port, same-cycle data
//  wb_valid/wb_rd                      : writeback retiring a register write
//  ex_valid/ex_ready/ex_*              : single-entry ID/EX register to execute
// Handshake (both sides): a transfer happens on a cycle where valid && ready.
// While valid && !ready the producer holds valid and payload stable. if_ready
// is allowed to depend on if_instr (hazard check against the scoreboard).
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            rf_en,
  output logic [5:0]      rf_reg_a,
  output logic [5:0]      rf_reg_b,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output op_t             ex_op,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_wb_en,
  output logic            ex_illegal
);

  decoded_t dec;

  rv_decoder u_dec (.instr(if_instr), .dec(dec));

  logic                ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]     ex_pc_q, ex_pc_d;
  op_t                 ex_op_q, ex_op_d;
  logic [XLEN-1:0]     ex_rs1_val_q, ex_rs1_val_d;
  logic [XLEN-1:0]     ex_rs2_val_q, ex_rs2_val_d;
  logic [XLEN-1:0]     ex_imm_q, ex_imm_d;
  logic [4:0]          ex_rd_q, ex_rd_d;
  logic                ex_wb_en_q, ex_wb_en_d;
  logic                ex_illegal_q, ex_illegal_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;

  logic hazard;
  logic accept;

  // Register file is read straight from the fetched word; its own reset
  // must keep working, so the enable is never dropped.
  assign rf_en    = 1'b1;
  assign rf_reg_a = {1'b0, dec.rs1};
  assign rf_reg_b = {1'b0, dec.rs2};

  // No bypass: any pending write to a source (RAW) or to rd (WAW) stalls.
  // A writeback in this same cycle does not help yet -- the clear lands on
  // the same edge as the register-file write.
  assign hazard = (dec.uses_rs1 && pend_q[dec.rs1]) ||
                  (dec.uses_rs2 && pend_q[dec.rs2]) ||
                  (dec.wr_rd    && pend_q[dec.rd]);

  assign if_ready = (!ex_valid_q || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_op_d      = ex_op_q;
    ex_rs1_val_d = ex_rs1_val_q;
    ex_rs2_val_d = ex_rs2_val_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_wb_en_d   = ex_wb_en_q;
    ex_illegal_d = ex_illegal_q;
    pend_d       = pend_q;

    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = if_pc;
      ex_op_d      = dec.op;
      ex_rs1_val_d = rf_data_a;
      ex_rs2_val_d = rf_data_b;
      ex_imm_d     = XLEN'($signed(dec.imm));
      ex_rd_d      = dec.rd;
      ex_wb_en_d   = dec.wr_rd && (dec.rd != 5'd0);
      ex_illegal_d = dec.illegal;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end

    // Clears first so that a same-cycle set on the same index wins.
    if (wb_valid) pend_d[wb_rd] = 1'b0;
    // A killed writer will never retire, so its reservation is dropped here.
    if (flush && ex_valid_q && ex_wb_en_q) pend_d[ex_rd_q] = 1'b0;
    if (accept && dec.wr_rd && (dec.rd != 5'd0)) pend_d[dec.rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_op_q      <= OP_NOP;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      ex_wb_en_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_op_q      <= ex_op_d;
      ex_rs1_val_q <= ex_rs1_val_d;
      ex_rs2_val_q <= ex_rs2_val_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_wb_en_q   <= ex_wb_en_d;
      ex_illegal_q <= ex_illegal_d;
      pend_q       <= pend_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_op      = ex_op_q;
  assign ex_rs1_val = ex_rs1_val_q;
  assign ex_rs2_val = ex_rs2_val_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rd      = ex_rd_q;
  assign ex_wb_en   = ex_wb_en_q;
  assign ex_illegal = ex_illegal_q;

endmodule
